// File: rtl/vscale_hasti_ws_slave_if.sv
// rtl/vscale_hasti_ws_slave_if.sv - HASTI (AHB-Lite) bus bundle between a master and the wait-state scratchpad slave
//
// Signals: haddr/hwrite/hsize/hburst/hmastlock/hprot/htrans/hwdata are driven by the master;
// hrdata/hready/hresp/err_count are driven by the slave.
// Modports: master (initiator side), slave (responder side).
interface vscale_hasti_ws_slave_if;
    logic [31:0] haddr;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [2:0]  hburst;
    logic        hmastlock;
    logic [3:0]  hprot;
    logic [1:0]  htrans;
    logic [31:0] hwdata;
    logic [31:0] hrdata;
    logic        hready;
    logic        hresp;
    logic [7:0]  err_count;

    modport master (
        output haddr, hwrite, hsize, hburst, hmastlock, hprot, htrans, hwdata,
        input  hrdata, hready, hresp, err_count
    );

    modport slave (
        input  haddr, hwrite, hsize, hburst, hmastlock, hprot, htrans, hwdata,
        output hrdata, hready, hresp, err_count
    );
endinterface

// File: rtl/vscale_hasti_ws_slave.sv
// rtl/vscale_hasti_ws_slave.sv - HASTI scratchpad SRAM slave with programmable wait states and two-cycle ERROR responses
//
// Ports:
//   clk   - single clock
//   reset - asynchronous, active-high reset
//   bus   - HASTI slave modport (address/control/write data in; hrdata, hready, hresp, err_count out)
// Parameters:
//   MEM_WORDS   - depth in 32-bit words (power of two, >= 2)
//   WAIT_CYCLES - wait states inserted per OKAY transfer (0..15)
module vscale_hasti_ws_slave #(
    parameter int MEM_WORDS   = 256,
    parameter int WAIT_CYCLES = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    vscale_hasti_ws_slave_if.slave  bus
);
    localparam int          IDX_W      = $clog2(MEM_WORDS);
    localparam logic [3:0]  WAIT_INIT  = 4'(WAIT_CYCLES);
    localparam logic [32:0] ADDR_LIMIT = 33'(4 * MEM_WORDS);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_DONE,
        ST_ERR1,
        ST_ERR2
    } state_t;

    state_t             state_q, state_d;
    logic [3:0]         cnt_q, cnt_d;
    logic               hready_q, hready_d;
    logic               hresp_q, hresp_d;
    logic [31:0]        hrdata_q;
    logic [7:0]         err_count_q;
    logic               hwrite_q;
    logic [2:0]         hsize_q;
    logic [1:0]         addr_lo_q;
    logic [IDX_W-1:0]   widx_q;
    logic [31:0]        mem_q [MEM_WORDS];

    logic               accept;
    logic               acc_err;
    logic [IDX_W-1:0]   acc_idx;
    logic [3:0]         wr_be;
    logic               wr_en;
    logic [31:0]        wr_word;
    logic               rd_en;
    logic [IDX_W-1:0]   rd_idx;
    logic [31:0]        rd_word;

    // Bits the responder never looks at (burst/lock/prot, address bits above the array).
    wire unused_bus = &{1'b0, bus.hburst, bus.hmastlock, bus.hprot, bus.haddr[31:IDX_W+2]};

    assign accept  = hready_q && bus.htrans[1];
    assign acc_idx = bus.haddr[IDX_W+1:2];
    assign acc_err = ({1'b0, bus.haddr} >= ADDR_LIMIT) ||
                     (bus.hsize >= 3'd3) ||
                     (bus.hsize == 3'd1 && bus.haddr[0]) ||
                     (bus.hsize == 3'd2 && bus.haddr[1:0] != 2'b00);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = ST_DONE;
                end
            end
            ST_ERR1: state_d = ST_ERR2;
            default: begin
                // IDLE, DONE and ERR2 all present hready=1 and may take a new address.
                if (!accept) begin
                    state_d = ST_IDLE;
                end else if (acc_err) begin
                    state_d = ST_ERR1;
                end else if (WAIT_CYCLES == 0) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_WAIT;
                    cnt_d   = WAIT_INIT;
                end
            end
        endcase
        hready_d = (state_d == ST_IDLE) || (state_d == ST_DONE) || (state_d == ST_ERR2);
        hresp_d  = (state_d == ST_ERR1) || (state_d == ST_ERR2);
    end

    // Byte lanes of the transfer currently in its last data-phase cycle.
    always_comb begin
        wr_be = 4'b0000;
        case (hsize_q)
            3'd0:    wr_be = 4'b0001 << addr_lo_q;
            3'd1:    wr_be = addr_lo_q[1] ? 4'b1100 : 4'b0011;
            default: wr_be = 4'b1111;
        endcase
    end

    assign wr_en = (state_q == ST_DONE) && hwrite_q;

    always_comb begin
        wr_word = mem_q[widx_q];
        for (int i = 0; i < 4; i++) begin
            if (wr_be[i]) begin
                wr_word[8*i +: 8] = bus.hwdata[8*i +: 8];
            end
        end
    end

    // The transfer entering DONE is the captured one when leaving WAIT, otherwise the
    // one being accepted right now (zero-wait configuration).
    always_comb begin
        if (state_q == ST_WAIT) begin
            rd_idx = widx_q;
            rd_en  = (state_d == ST_DONE) && !hwrite_q;
        end else begin
            rd_idx = acc_idx;
            rd_en  = (state_d == ST_DONE) && !bus.hwrite;
        end
        // A write committing on this same edge must be visible to the read.
        rd_word = (wr_en && widx_q == rd_idx) ? wr_word : mem_q[rd_idx];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 4'd0;
            hready_q    <= 1'b1;
            hresp_q     <= 1'b0;
            hrdata_q    <= 32'd0;
            err_count_q <= 8'd0;
            hwrite_q    <= 1'b0;
            hsize_q     <= 3'd0;
            addr_lo_q   <= 2'd0;
            widx_q      <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            hready_q <= hready_d;
            hresp_q  <= hresp_d;
            if (accept) begin
                hwrite_q  <= bus.hwrite;
                hsize_q   <= bus.hsize;
                addr_lo_q <= bus.haddr[1:0];
                widx_q    <= acc_idx;
            end
            if (rd_en) begin
                hrdata_q <= rd_word;
            end
            if (state_d == ST_ERR1 && err_count_q != 8'hFF) begin
                err_count_q <= err_count_q + 8'd1;
            end
        end
    end

    // Storage is not reset; a write still pending while reset is high is dropped.
    always_ff @(posedge clk) begin
        if (wr_en && !reset) begin
            mem_q[widx_q] <= wr_word;
        end
    end

    assign bus.hrdata    = hrdata_q;
    assign bus.hready    = hready_q;
    assign bus.hresp     = hresp_q;
    assign bus.err_count = err_count_q;
endmodule
